// File: rtl/dual_input_conditioner_pkg.sv
// Shared types and defaults for the two-channel switch debouncer.
package dual_input_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } db_state_t;

  localparam int unsigned DEF_STABLE_COUNT = 50000;
  localparam int unsigned DEF_CNT_W        = 16;

  // Debounced level implied by a state: high while settled high or qualifying a fall.
  function automatic logic level_of(input db_state_t s);
    return (s == IDLE_HIGH) || (s == WAIT_LOW);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchronizer, qualification FSM with stability
// counter, registered level and rising-edge strobe.
module debounce_ch
  import dual_input_conditioner_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = DEF_STABLE_COUNT,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT - 1);

  logic             sync1;
  logic             sync2;
  db_state_t        state;
  db_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             level_next;
  logic             pulse_next;

  // Metastability guard for the asynchronous switch input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      level <= level_next;
      pulse <= pulse_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    level_next = 1'b0;
    pulse_next = 1'b0;

    case (state)
      IDLE_LOW: begin
        if (sync2) begin
          state_next = WAIT_HIGH;
          cnt_next   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2) begin
          state_next = IDLE_LOW;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next = IDLE_HIGH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!sync2) begin
          state_next = WAIT_LOW;
          cnt_next   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync2) begin
          state_next = IDLE_HIGH;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next = IDLE_LOW;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE_LOW;
        cnt_next   = '0;
      end
    endcase

    // Level is decoded from the next state so it lands on the same edge as the state.
    level_next = level_of(state_next);
    pulse_next = level_next & ~level;
  end

endmodule

// File: rtl/dual_input_conditioner.sv
// Two independent debounced switch inputs feeding the downstream XOR stage.
module dual_input_conditioner
  import dual_input_conditioner_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = DEF_STABLE_COUNT,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic A,
  output logic B,
  output logic A_pulse,
  output logic B_pulse
);

  debounce_ch #(
    .STABLE_COUNT(STABLE_COUNT),
    .CNT_W       (CNT_W)
  ) u_a (
    .clk  (clk),
    .reset(reset),
    .raw  (a_raw),
    .level(A),
    .pulse(A_pulse)
  );

  debounce_ch #(
    .STABLE_COUNT(STABLE_COUNT),
    .CNT_W       (CNT_W)
  ) u_b (
    .clk  (clk),
    .reset(reset),
    .raw  (b_raw),
    .level(B),
    .pulse(B_pulse)
  );

endmodule
